// File: rtl/hazard_tracker.sv
// hazard_tracker: E/M/W write scoreboard for a 5-stage MIPS pipeline.
// In: D-stage decode (rs/rt, tuse, a3, rfwr, tnew). Out: stall, fwd selects, stall_cnt.
module hazard_tracker #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [1:0]        d_tuse_rs,
    input  logic [1:0]        d_tuse_rt,
    input  logic [REG_AW-1:0] d_a3,
    input  logic              d_rfwr,
    input  logic [1:0]        d_tnew,
    output logic              stall,
    output logic [1:0]        fwd_d_rs,
    output logic [1:0]        fwd_d_rt,
    output logic [1:0]        fwd_e_rs,
    output logic [1:0]        fwd_e_rt,
    output logic [1:0]        fwd_m_rt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] a3;
        logic [1:0]        tnew;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } rec_t;

    rec_t e_q, m_q, w_q;
    rec_t e_d;
    logic stall_rs, stall_rt;

    function automatic logic writes(rec_t r, logic [REG_AW-1:0] a);
        return r.valid && (r.a3 == a) && (a != '0);
    endfunction

    // Advance one stage: result gets one cycle closer, floor at 0.
    function automatic rec_t shift(rec_t r);
        rec_t o;
        o = r;
        o.tnew = (r.tnew == 2'd0) ? 2'd0 : r.tnew - 2'd1;
        return o;
    endfunction

    // Only the youngest writer matters; W is always ready.
    function automatic logic op_stall(rec_t e, rec_t m,
                                      logic [REG_AW-1:0] x,
                                      logic [1:0] tuse);
        logic s;
        s = 1'b0;
        if (tuse == 2'd3 || x == '0)
            s = 1'b0;
        else if (writes(e, x))
            s = (e.tnew > tuse);
        else if (writes(m, x))
            s = (m.tnew > tuse);
        return s;
    endfunction

    // An unready younger match blocks older ones (stall covers it).
    function automatic logic [1:0] sel_d(rec_t e, rec_t m, rec_t w,
                                         logic [REG_AW-1:0] x);
        logic [1:0] s;
        s = 2'd0;
        if (writes(e, x))
            s = (e.tnew == 2'd0) ? 2'd1 : 2'd0;
        else if (writes(m, x))
            s = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (writes(w, x))
            s = 2'd3;
        return s;
    endfunction

    function automatic logic [1:0] sel_e(rec_t m, rec_t w,
                                         logic [REG_AW-1:0] x);
        logic [1:0] s;
        s = 2'd0;
        if (writes(m, x))
            s = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (writes(w, x))
            s = 2'd3;
        return s;
    endfunction

    always_comb begin
        stall_rs = op_stall(e_q, m_q, d_rs, d_tuse_rs);
        stall_rt = op_stall(e_q, m_q, d_rt, d_tuse_rt);
        stall    = d_valid & (stall_rs | stall_rt);
        e_d      = '0;
        if (!stall) begin
            e_d.valid = d_valid;
            e_d.a3    = d_rfwr ? d_a3 : '0;
            e_d.tnew  = d_tnew;
            e_d.rs    = d_rs;
            e_d.rt    = d_rt;
        end
    end

    assign fwd_d_rs = sel_d(e_q, m_q, w_q, d_rs);
    assign fwd_d_rt = sel_d(e_q, m_q, w_q, d_rt);
    assign fwd_e_rs = sel_e(m_q, w_q, e_q.rs);
    assign fwd_e_rt = sel_e(m_q, w_q, e_q.rt);
    assign fwd_m_rt = writes(w_q, m_q.rt) ? 2'd3 : 2'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            stall_cnt <= '0;
        end else begin
            e_q <= e_d;
            m_q <= shift(e_q);
            w_q <= shift(m_q);
            if (stall)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Fields kept for record completeness but never read.
    logic unused;
    assign unused = ^{w_q.tnew, w_q.rs, w_q.rt, m_q.rs};

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed MIPS hazard sequences checked against an
// age-based pipeline model plus hand-computed literal expectations.
module tb_hazard_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        d_valid = 1'b0;
    logic [4:0]  d_rs = '0, d_rt = '0, d_a3 = '0;
    logic [1:0]  d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
    logic        d_rfwr = 1'b0;
    logic        stall;
    logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
    logic [31:0] stall_cnt;

    int n_chk = 0;
    int n_fail = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    hazard_tracker dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_a3(d_a3), .d_rfwr(d_rfwr), .d_tnew(d_tnew),
        .stall(stall),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
        .fwd_m_rt(fwd_m_rt), .stall_cnt(stall_cnt)
    );

    // Model: hist[a] is the instruction that entered E a cycles ago
    // (0=E, 1=M, 2=W). Its result is ready once a >= original tnew.
    bit hv[3];
    int hrd[3], htn[3], hrs[3], hrt[3];
    int m_cnt = 0;

    function automatic int rem(int a);
        return (htn[a] > a) ? htn[a] - a : 0;
    endfunction

    function automatic bit wr(int a, int r);
        return hv[a] && r != 0 && hrd[a] == r;
    endfunction

    function automatic bit mstall_op(int r, int tuse);
        if (tuse == 3 || r == 0) return 1'b0;
        for (int a = 0; a < 2; a++)
            if (wr(a, r)) return rem(a) > tuse;
        return 1'b0;
    endfunction

    function automatic bit mstall();
        return d_valid && (mstall_op(int'(d_rs), int'(d_tuse_rs)) ||
                           mstall_op(int'(d_rt), int'(d_tuse_rt)));
    endfunction

    // Youngest writer at or older than stage lo; unready -> 0.
    function automatic int mfwd(int r, int lo);
        for (int a = lo; a < 3; a++)
            if (wr(a, r)) return (rem(a) == 0) ? a + 1 : 0;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 3; a++) begin
                hv[a] = 1'b0; hrd[a] = 0; htn[a] = 0;
                hrs[a] = 0; hrt[a] = 0;
            end
            m_cnt = 0;
        end else begin : upd
            bit s;
            s = mstall();
            if (s) m_cnt++;
            for (int a = 2; a > 0; a--) begin
                hv[a] = hv[a-1]; hrd[a] = hrd[a-1]; htn[a] = htn[a-1];
                hrs[a] = hrs[a-1]; hrt[a] = hrt[a-1];
            end
            hv[0]  = s ? 1'b0 : d_valid;
            hrd[0] = (s || !d_rfwr) ? 0 : int'(d_a3);
            htn[0] = s ? 0 : int'(d_tnew);
            hrs[0] = s ? 0 : int'(d_rs);
            hrt[0] = s ? 0 : int'(d_rt);
        end
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("m_stall", stall, mstall());
            check("m_fwd_d_rs", fwd_d_rs, mfwd(int'(d_rs), 0));
            check("m_fwd_d_rt", fwd_d_rt, mfwd(int'(d_rt), 0));
            check("m_fwd_e_rs", fwd_e_rs, mfwd(hrs[0], 1));
            check("m_fwd_e_rt", fwd_e_rt, mfwd(hrt[0], 1));
            check("m_fwd_m_rt", fwd_m_rt, mfwd(hrt[1], 2));
            check("m_stall_cnt", stall_cnt, m_cnt);
        end
    end

    task automatic setd(bit v, int rs, int rt, int trs, int trt,
                        int a3, bit w, int tn);
        d_valid = v; d_rs = 5'(rs); d_rt = 5'(rt);
        d_tuse_rs = 2'(trs); d_tuse_rt = 2'(trt);
        d_a3 = 5'(a3); d_rfwr = w; d_tnew = 2'(tn);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        setd(1'b0, 0, 0, 3, 3, 0, 1'b0, 0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        nop();
        tick();
        tick();
        reset = 1'b0;
        started = 1'b1;

        // Reset state with a hazard-looking instruction in D
        setd(1'b1, 1, 1, 0, 0, 1, 1'b1, 2);
        check("rst_stall", stall, 0);
        check("rst_fwd_d_rs", fwd_d_rs, 0);
        check("rst_fwd_e_rs", fwd_e_rs, 0);
        check("rst_fwd_m_rt", fwd_m_rt, 0);
        check("rst_cnt", stall_cnt, 0);
        drain();

        // lw $1 ; add $2,$1,$3
        setd(1'b1, 0, 1, 1, 3, 1, 1'b1, 2);
        tick();
        setd(1'b1, 1, 3, 1, 1, 2, 1'b1, 1);
        check("lwadd_stall1", stall, 1);
        tick();
        check("lwadd_stall2", stall, 0);
        tick();
        nop();
        check("lwadd_fwd_e_rs", fwd_e_rs, 3);
        drain();

        // lw $1 ; beq $1,$0
        do_reset();
        setd(1'b1, 0, 1, 1, 3, 1, 1'b1, 2);
        tick();
        setd(1'b1, 1, 0, 0, 0, 0, 1'b0, 0);
        check("lwbeq_stall1", stall, 1);
        tick();
        check("lwbeq_stall2", stall, 1);
        tick();
        check("lwbeq_stall3", stall, 0);
        check("lwbeq_fwd_d_rs", fwd_d_rs, 3);
        check("lwbeq_cnt", stall_cnt, 2);
        tick();
        drain();

        // add $4,$5,$6 ; beq $4,$4
        setd(1'b1, 5, 6, 1, 1, 4, 1'b1, 1);
        tick();
        setd(1'b1, 4, 4, 0, 0, 0, 1'b0, 0);
        check("addbeq_stall1", stall, 1);
        tick();
        check("addbeq_stall2", stall, 0);
        check("addbeq_fwd_d_rs", fwd_d_rs, 2);
        check("addbeq_fwd_d_rt", fwd_d_rt, 2);
        tick();
        drain();

        // jal ; jr $31
        setd(1'b1, 0, 0, 3, 3, 31, 1'b1, 0);
        tick();
        setd(1'b1, 31, 0, 0, 3, 0, 1'b0, 0);
        check("jaljr_stall", stall, 0);
        check("jaljr_fwd_d_rs", fwd_d_rs, 1);
        tick();
        drain();

        // ori $0,$0,5 ; add $5,$0,$0
        setd(1'b1, 0, 0, 1, 3, 0, 1'b1, 1);
        tick();
        setd(1'b1, 0, 0, 1, 1, 5, 1'b1, 1);
        check("r0_stall", stall, 0);
        check("r0_fwd_d_rs", fwd_d_rs, 0);
        check("r0_fwd_d_rt", fwd_d_rt, 0);
        tick();
        nop();
        check("r0_fwd_e_rs", fwd_e_rs, 0);
        check("r0_fwd_e_rt", fwd_e_rt, 0);
        drain();

        // lw $1,0($3) ; sw $1,0($2)
        setd(1'b1, 3, 0, 1, 3, 1, 1'b1, 2);
        tick();
        setd(1'b1, 2, 1, 1, 2, 0, 1'b0, 0);
        check("lwsw_stall", stall, 0);
        tick();
        nop();
        check("lwsw_fwd_e_rt", fwd_e_rt, 0);
        tick();
        check("lwsw_fwd_m_rt", fwd_m_rt, 3);
        drain();

        // ori $1 ; lw $1 ; beq $1,$1 : unready E masks ready M
        setd(1'b1, 0, 0, 1, 3, 1, 1'b1, 1);
        tick();
        setd(1'b1, 0, 1, 1, 3, 1, 1'b1, 2);
        tick();
        setd(1'b1, 1, 1, 0, 0, 0, 1'b0, 0);
        check("shadow_stall", stall, 1);
        check("shadow_fwd_d_rs", fwd_d_rs, 0);
        drain();

        // Reset during a stall
        setd(1'b1, 0, 1, 1, 3, 1, 1'b1, 2);
        tick();
        setd(1'b1, 1, 1, 0, 0, 0, 1'b0, 0);
        check("rststall_pre", stall, 1);
        do_reset();
        check("rststall_stall", stall, 0);
        check("rststall_cnt", stall_cnt, 0);
        check("rststall_fwd_d_rs", fwd_d_rs, 0);
        check("rststall_fwd_d_rt", fwd_d_rt, 0);
        check("rststall_fwd_e_rs", fwd_e_rs, 0);
        check("rststall_fwd_m_rt", fwd_m_rt, 0);
        drain();

        @(posedge clk);
        started = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
